// File: rtl/mul_rr_arbiter.sv
// ============================================================================
// Module   : mul_rr_arbiter
// Purpose  : Round-robin sequencer sharing one pipelined WxW multiplier among
//            N_REQ requesters, with ID-tagged one-cycle response strobes.
//            Define MUL_RR_ARBITER_FIXED_PRIO_EN for fixed lowest-index priority.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mul_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int W     = 4,
    parameter int LAT   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*W-1:0]   req_a,
    input  logic [N_REQ*W-1:0]   req_b,
    output logic [N_REQ-1:0]     req_ready,
    output logic [W-1:0]         mul_a,
    output logic [W-1:0]         mul_b,
    input  logic [2*W-1:0]       mul_p,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [2*W-1:0]       rsp_data,
    output logic                 busy
);

    // One tag stage for the operand register feeding the multiplier, then
    // LAT+1 more so the final tag lines up with the product register output.
    localparam int STAGES = LAT + 2;

    logic [ID_W-1:0]              w_ptr;
    logic                         w_lo_any;
    logic                         w_hi_any;
    logic [ID_W-1:0]              w_lo_id;
    logic [ID_W-1:0]              w_hi_id;
    logic                         w_any;
    logic [ID_W-1:0]              w_gid;
    logic [N_REQ-1:0]             w_ready;
    logic [W-1:0]                 w_a;
    logic [W-1:0]                 w_b;

    logic [W-1:0]                 r_mul_a;
    logic [W-1:0]                 r_mul_b;
    logic [STAGES-1:0]            r_tag_v;
    logic [STAGES-1:0][ID_W-1:0]  r_tag_id;

`ifdef MUL_RR_ARBITER_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [ID_W-1:0]              r_ptr;

    assign w_ptr = r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= (w_gid == ID_W'(N_REQ - 1)) ? '0 : w_gid + 1'b1;
        end
    end
`endif

    // Lowest requester at/after ptr wins; otherwise wrap to the lowest overall.
    always_comb begin
        w_lo_any = 1'b0;
        w_hi_any = 1'b0;
        w_lo_id  = '0;
        w_hi_id  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_lo_any = 1'b1;
                w_lo_id  = ID_W'(i);
                if (i >= int'(w_ptr)) begin
                    w_hi_any = 1'b1;
                    w_hi_id  = ID_W'(i);
                end
            end
        end
        w_any = en && w_lo_any;
        if (!w_any)
            w_gid = '0;
        else if (w_hi_any)
            w_gid = w_hi_id;
        else
            w_gid = w_lo_id;
    end

    always_comb begin
        w_ready = '0;
        w_a     = '0;
        w_b     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_ready[i] = w_any && (w_gid == ID_W'(i));
            if (w_ready[i]) begin
                w_a = req_a[i*W +: W];
                w_b = req_b[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mul_a  <= '0;
            r_mul_b  <= '0;
            r_tag_v  <= '0;
            r_tag_id <= '0;
        end else begin
            r_mul_a  <= w_any ? w_a : '0;
            r_mul_b  <= w_any ? w_b : '0;
            r_tag_v  <= {r_tag_v[STAGES-2:0], w_any};
            r_tag_id <= {r_tag_id[STAGES-2:0], w_gid};
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_valid[i] = r_tag_v[STAGES-1] && (r_tag_id[STAGES-1] == ID_W'(i));
        end
    end

    assign req_ready = w_ready;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign rsp_id    = r_tag_id[STAGES-1];
    assign rsp_data  = mul_p;
    assign busy      = |r_tag_v;

endmodule

`default_nettype wire

// File: tb/tb_mul_rr_arbiter.sv
// ============================================================================
// Module   : tb_mul_rr_arbiter
// Purpose  : Self-checking bench for mul_rr_arbiter with a multiplier model
//            and a queue-based reference of grants and responses.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mul_rr_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int W   = 4;
    localparam int LAT = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N*W-1:0]   req_a = '0;
    logic [N*W-1:0]   req_b = '0;
    logic [N-1:0]     req_ready;
    logic [W-1:0]     mul_a;
    logic [W-1:0]     mul_b;
    logic [2*W-1:0]   mul_p = '0;
    logic [N-1:0]     rsp_valid;
    logic [IDW-1:0]   rsp_id;
    logic [2*W-1:0]   rsp_data;
    logic             busy;

    mul_rr_arbiter #(.N_REQ(N), .ID_W(IDW), .W(W), .LAT(LAT)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Multiplier: operand capture register followed by LAT stages.
    logic [2*W-1:0] m1 = '0, m2 = '0, m3 = '0;
    always @(posedge clk) begin
        m1    <= {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
        m2    <= m1;
        m3    <= m2;
        mul_p <= m3;
    end

    typedef struct {
        int id;
        int prod;
        int due;
    } rsp_t;

    rsp_t q[$];
    int   cyc = 0;
    int   m_ptr = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_grant();
        int idx;
        if (!en) return -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    // One clock: check grant and response state, advance the model at the edge.
    task automatic step();
        int   g;
        rsp_t r;
        #1;
        g = exp_grant();
        chk("req_ready", 32'(req_ready), (g < 0) ? 0 : (1 << g));
        if (q.size() > 0 && q[0].due == cyc) begin
            chk("rsp_valid", 32'(rsp_valid), 1 << q[0].id);
            chk("rsp_id",    32'(rsp_id),    q[0].id);
            chk("rsp_data",  32'(rsp_data),  q[0].prod);
        end else begin
            chk("rsp_idle", 32'(rsp_valid), 0);
        end
        chk("busy", 32'(busy), (q.size() > 0) ? 1 : 0);
        if (g >= 0) begin
            r.id   = g;
            r.prod = int'(req_a[g*W +: W]) * int'(req_b[g*W +: W]);
        end
        @(posedge clk);
        if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
        cyc++;
        if (g >= 0) begin
            r.due = cyc + LAT + 1;
            q.push_back(r);
`ifndef MUL_RR_ARBITER_FIXED_PRIO_EN
            m_ptr = (g + 1) % N;
`endif
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_busy",  32'(busy), 0);
        chk("rst_rsp",   32'(rsp_valid), 0);
        chk("rst_rspid", 32'(rsp_id), 0);
        chk("rst_mul_a", 32'(mul_a), 0);
        chk("rst_mul_b", 32'(mul_b), 0);
        q.delete();
        m_ptr = 0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_a[i*W +: W] = W'(a);
        req_b[i*W +: W] = W'(b);
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Single request: requester 1, 7*9
        en = 1'b1;
        set_op(1, 7, 9);
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        repeat (6) step();

        // Fairness from ptr 0 with all requesters active
        do_reset();
        set_op(0, 15, 15); set_op(1, 3, 5); set_op(2, 10, 11); set_op(3, 0, 12);
        req_valid = 4'b1111;
        repeat (8) step();
        req_valid = '0;
        repeat (6) step();

        // Partial requests from ptr 1
        do_reset();
        req_valid = 4'b0001;
        step();
        req_valid = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            set_op(0, k + 2, 3); set_op(2, 13, k + 1);
            step();
        end
        req_valid = '0;
        repeat (6) step();

        // en gating mid-stream, then resume from the saved pointer
        req_valid = 4'b1111;
        step();
        en = 1'b0;
        repeat (5) step();
        en = 1'b1;
        repeat (3) step();
        req_valid = '0;
        repeat (6) step();

        // Reset with operations in flight
        req_valid = 4'b0011;
        repeat (2) step();
        req_valid = '0;
        step();
        do_reset();
        set_op(1, 7, 9);
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        repeat (6) step();

        // Two low requesters held (fixed priority starves requester 1)
        req_valid = 4'b0011;
        repeat (6) step();
        req_valid = '0;
        repeat (6) step();

        // Randomized traffic with changing operands and en toggling
        for (int k = 0; k < 300; k++) begin
            req_valid = N'($urandom);
            req_a     = (N*W)'($urandom);
            req_b     = (N*W)'($urandom);
            en        = ($urandom_range(0, 9) < 8);
            step();
        end
        req_valid = '0;
        repeat (7) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
